// File: rtl/bomba_alternador_if.sv
// Pin bundle between the board sensor/contactor side and the lead/lag pump scheduler.
// The scheduler takes the slave view; whatever drives the pins takes the master view.
interface bomba_alternador_if;
  logic       ena_i;
  logic [2:0] sensores_i;
  logic [1:0] fallo_i;
  logic       borrar_i;
  logic [1:0] bomba_o;
  logic       lider_o;
  logic       alarma_o;
  logic [1:0] causa_o;
  logic [2:0] estado_o;

  modport master (
    output ena_i, sensores_i, fallo_i, borrar_i,
    input  bomba_o, lider_o, alarma_o, causa_o, estado_o
  );

  modport slave (
    input  ena_i, sensores_i, fallo_i, borrar_i,
    output bomba_o, lider_o, alarma_o, causa_o, estado_o
  );
endinterface

// File: rtl/bomba_alternador.sv
// Lead/lag scheduler for two fill pumps on one tank: debounced 3-level sensing,
// lead alternation, lag assist, minimum off time, run timeout and a latched alarm.
module bomba_alternador #(
  parameter int DEB       = 4,
  parameter int LAG_DELAY = 16,
  parameter int MAX_RUN   = 64,
  parameter int MIN_OFF   = 8
) (
  input logic               clk,
  input logic               rst_n,
  bomba_alternador_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LLENA1 = 2'd1;
  localparam logic [1:0] LLENA2 = 2'd2;
  localparam logic [1:0] FALLA  = 2'd3;

  localparam logic [1:0] CAUSA_NONE    = 2'b00;
  localparam logic [1:0] CAUSA_SENS    = 2'b01;
  localparam logic [1:0] CAUSA_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSA_BOTH    = 2'b11;

  localparam logic [15:0] DEB_N    = 16'(DEB);
  localparam logic [15:0] LAG_LAST = 16'(LAG_DELAY - 1);
  localparam logic [15:0] RUN_LAST = 16'(MAX_RUN - 1);
  localparam logic [15:0] OFF_MIN  = 16'(MIN_OFF);

  logic [2:0]  sensSync1_q, sensSync2_q;
  logic [1:0]  falloSync1_q, falloSync2_q;
  logic [2:0]  niv_q, niv_d;
  logic [2:0]  cand_q, cand_d;
  logic [15:0] debCnt_q, debCnt_d;
  logic [15:0] debNext;

  logic [1:0]  state_q, state_d;
  logic        lider_q, lider_d;
  logic [1:0]  causa_q, causa_d;
  logic [15:0] offCnt_q, offCnt_d;
  logic [15:0] runCnt_q, runCnt_d;

  logic        nivValid;
  logic        bothFail;
  logic        leadFail;
  logic        lagFail;

  // Sensor synchronizers reset to "tank full" so the filter starts settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sensSync1_q  <= 3'b111;
      sensSync2_q  <= 3'b111;
      falloSync1_q <= 2'b00;
      falloSync2_q <= 2'b00;
    end else begin
      sensSync1_q  <= bus.sensores_i;
      sensSync2_q  <= sensSync1_q;
      falloSync1_q <= bus.fallo_i;
      falloSync2_q <= falloSync1_q;
    end
  end

  // A new level is accepted only after DEB identical samples that differ from it.
  always_comb begin
    niv_d    = niv_q;
    cand_d   = cand_q;
    debCnt_d = debCnt_q;
    debNext  = (sensSync2_q == cand_q) ? debCnt_q + 16'd1 : 16'd1;
    if (sensSync2_q == niv_q) begin
      debCnt_d = '0;
    end else begin
      cand_d = sensSync2_q;
      if (debNext >= DEB_N) begin
        niv_d    = sensSync2_q;
        debCnt_d = '0;
      end else begin
        debCnt_d = debNext;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      niv_q    <= 3'b111;
      cand_q   <= 3'b111;
      debCnt_q <= '0;
    end else begin
      niv_q    <= niv_d;
      cand_q   <= cand_d;
      debCnt_q <= debCnt_d;
    end
  end

  always_comb begin
    nivValid = (niv_q == 3'b000) || (niv_q == 3'b001) ||
               (niv_q == 3'b011) || (niv_q == 3'b111);
    bothFail = &falloSync2_q;
    leadFail = falloSync2_q[lider_q];
    lagFail  = falloSync2_q[~lider_q];
  end

  // Branch order encodes the priority: sensors, double fault, enable, timeout,
  // lead fault, tank full, lag start.
  always_comb begin
    state_d  = state_q;
    lider_d  = lider_q;
    causa_d  = causa_q;
    offCnt_d = (state_q == IDLE && offCnt_q < OFF_MIN) ? offCnt_q + 16'd1 : offCnt_q;
    runCnt_d = (state_q == LLENA1 || state_q == LLENA2) ? runCnt_q + 16'd1 : runCnt_q;

    if (state_q == FALLA) begin
      if (bus.borrar_i && nivValid && !bothFail) begin
        state_d  = IDLE;
        causa_d  = CAUSA_NONE;
        offCnt_d = '0;
      end
    end else if (!nivValid) begin
      state_d = FALLA;
      causa_d = CAUSA_SENS;
    end else if (bothFail) begin
      state_d = FALLA;
      causa_d = CAUSA_BOTH;
    end else if (!bus.ena_i) begin
      if (state_q != IDLE) begin
        state_d  = IDLE;
        offCnt_d = '0;
      end
    end else if (state_q == IDLE) begin
      if (!niv_q[0] && offCnt_q >= OFF_MIN) begin
        state_d  = LLENA1;
        runCnt_d = '0;
        if (leadFail) begin
          lider_d = ~lider_q;
        end
      end
    end else if (runCnt_q == RUN_LAST) begin
      state_d = FALLA;
      causa_d = CAUSA_TIMEOUT;
    end else if (state_q == LLENA1) begin
      if (leadFail) begin
        lider_d = ~lider_q;
      end else if (niv_q[2]) begin
        state_d  = IDLE;
        offCnt_d = '0;
        if (!lagFail) begin
          lider_d = ~lider_q;
        end
      end else if (runCnt_q == LAG_LAST && !niv_q[0] && !lagFail) begin
        state_d = LLENA2;
      end
    end else begin
      // Both pumps running: a single fault drops back to the survivor alone.
      if (leadFail) begin
        state_d = LLENA1;
        lider_d = ~lider_q;
      end else if (lagFail) begin
        state_d = LLENA1;
      end else if (niv_q[2]) begin
        state_d  = IDLE;
        offCnt_d = '0;
        lider_d  = ~lider_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lider_q  <= 1'b0;
      causa_q  <= CAUSA_NONE;
      offCnt_q <= OFF_MIN;
      runCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lider_q  <= lider_d;
      causa_q  <= causa_d;
      offCnt_q <= offCnt_d;
      runCnt_q <= runCnt_d;
    end
  end

  always_comb begin
    case (state_q)
      LLENA1:  bus.bomba_o = lider_q ? 2'b10 : 2'b01;
      LLENA2:  bus.bomba_o = 2'b11;
      default: bus.bomba_o = 2'b00;
    endcase
    bus.lider_o  = lider_q;
    bus.alarma_o = (state_q == FALLA);
    bus.causa_o  = causa_q;
    bus.estado_o = {1'b0, state_q};
  end

endmodule

// File: tb/tb_bomba_alternador.sv
// Bench for the lead/lag pump scheduler: directed scenarios with literal expectations,
// then random pin activity, all checked every cycle against a timestamp-based model.
module tb_bomba_alternador;

  localparam int DEB       = 4;
  localparam int LAG_DELAY = 16;
  localparam int MAX_RUN   = 64;
  localparam int MIN_OFF   = 8;

  localparam int S_IDLE  = 0;
  localparam int S_LL1   = 1;
  localparam int S_LL2   = 2;
  localparam int S_FALLA = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  bomba_alternador_if bus ();

  bomba_alternador #(
    .DEB(DEB), .LAG_DELAY(LAG_DELAY), .MAX_RUN(MAX_RUN), .MIN_OFF(MIN_OFF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: fill/idle durations are edge-count differences rather than counters.
  int         mEdge;
  int         mState;
  int         mLead;
  int         mCause;
  int         mFillStart;
  int         mIdleStart;
  logic [2:0] mNiv;
  logic [2:0] sensPipe[$];
  logic [1:0] falloPipe[$];
  logic [2:0] sampWin[$];

  function automatic bit isValid(input logic [2:0] lvl);
    return (lvl == 3'b000) || (lvl == 3'b001) || (lvl == 3'b011) || (lvl == 3'b111);
  endfunction

  function automatic int expBomba();
    case (mState)
      S_LL1:   return 1 << mLead;
      S_LL2:   return 3;
      default: return 0;
    endcase
  endfunction

  task automatic modelReset();
    mState     = S_IDLE;
    mLead      = 0;
    mCause     = 0;
    mNiv       = 3'b111;
    mFillStart = 0;
    mIdleStart = -100000;
    sensPipe.delete();
    falloPipe.delete();
    sampWin.delete();
    repeat (2) begin
      sensPipe.push_back(3'b111);
      falloPipe.push_back(2'b00);
    end
  endtask

  task automatic modelStep();
    logic [2:0] samp;
    logic [1:0] f;
    bit         same;
    int         el;
    mEdge++;
    samp = sensPipe.pop_front();
    f    = falloPipe.pop_front();
    sensPipe.push_back(bus.sensores_i);
    falloPipe.push_back(bus.fallo_i);
    el = mEdge - mFillStart;

    if (mState == S_FALLA) begin
      if (bus.borrar_i && isValid(mNiv) && f != 2'b11) begin
        mState = S_IDLE; mCause = 0; mIdleStart = mEdge;
      end
    end else if (!isValid(mNiv)) begin
      mState = S_FALLA; mCause = 1;
    end else if (f == 2'b11) begin
      mState = S_FALLA; mCause = 3;
    end else if (!bus.ena_i) begin
      if (mState != S_IDLE) begin
        mState = S_IDLE; mIdleStart = mEdge;
      end
    end else if (mState == S_IDLE) begin
      if (!mNiv[0] && (mEdge - mIdleStart) > MIN_OFF) begin
        mState = S_LL1; mFillStart = mEdge;
        if (f[mLead]) mLead = 1 - mLead;
      end
    end else if (el == MAX_RUN) begin
      mState = S_FALLA; mCause = 2;
    end else if (mState == S_LL1) begin
      if (f[mLead]) mLead = 1 - mLead;
      else if (mNiv[2]) begin
        mState = S_IDLE; mIdleStart = mEdge;
        if (!f[1 - mLead]) mLead = 1 - mLead;
      end else if (el == LAG_DELAY && !mNiv[0] && !f[1 - mLead]) mState = S_LL2;
    end else begin
      if (f != 2'b00) begin
        mState = S_LL1; mLead = f[0] ? 1 : 0;
      end else if (mNiv[2]) begin
        mState = S_IDLE; mIdleStart = mEdge; mLead = 1 - mLead;
      end
    end

    sampWin.push_back(samp);
    if (sampWin.size() > DEB) void'(sampWin.pop_front());
    if (sampWin.size() == DEB) begin
      same = 1'b1;
      foreach (sampWin[i]) if (sampWin[i] != samp) same = 1'b0;
      if (same && samp != mNiv) mNiv = samp;
    end
  endtask

  task automatic cmp(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s at edge %0d: got %0d, want %0d", name, mEdge, act, req);
    end
  endtask

  task automatic checkOutput();
    cmp("bomba", int'(bus.bomba_o), expBomba());
    cmp("lider", int'(bus.lider_o), mLead);
    cmp("alarma", int'(bus.alarma_o), (mState == S_FALLA) ? 1 : 0);
    cmp("causa", int'(bus.causa_o), mCause);
    cmp("estado", int'(bus.estado_o), mState);
  endtask

  task automatic applyStimulus(input logic [2:0] sens, input logic [1:0] fallo,
                               input logic ena, input logic borrar);
    bus.sensores_i = sens;
    bus.fallo_i    = fallo;
    bus.ena_i      = ena;
    bus.borrar_i   = borrar;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clearAlarm();
    applyStimulus(3'b111, 2'b00, 1'b1, 1'b0);
    ticks(8);
    applyStimulus(3'b111, 2'b00, 1'b1, 1'b1);
    tick();
    applyStimulus(3'b111, 2'b00, 1'b1, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, want done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] validCodes[4];
    logic [2:0] badCodes[4];
    logic [2:0] sens;
    logic [1:0] fallo;
    int         holdS;
    int         holdF;
    validCodes = '{3'b000, 3'b001, 3'b011, 3'b111};
    badCodes   = '{3'b010, 3'b100, 3'b101, 3'b110};
    mEdge = 0;

    applyStimulus(3'b111, 2'b00, 1'b1, 1'b0);
    resetDut();
    @(negedge clk);
    cmp("rstBomba", int'(bus.bomba_o), 0);
    cmp("rstLider", int'(bus.lider_o), 0);
    cmp("rstAlarma", int'(bus.alarma_o), 0);
    cmp("rstCausa", int'(bus.causa_o), 0);
    cmp("rstEstado", int'(bus.estado_o), 0);

    // First fill starts on the 7th edge, lag joins 16 edges later.
    applyStimulus(3'b000, 2'b00, 1'b1, 1'b0);
    ticks(6);
    cmp("startEarly", int'(bus.bomba_o), 0);
    tick();
    cmp("firstStart", int'(bus.bomba_o), 1);
    ticks(15);
    cmp("lagEarly", int'(bus.bomba_o), 1);
    tick();
    cmp("lagStart", int'(bus.bomba_o), 3);
    cmp("lagEstado", int'(bus.estado_o), 2);
    applyStimulus(3'b111, 2'b00, 1'b1, 1'b0);
    ticks(7);
    cmp("fullBomba", int'(bus.bomba_o), 0);
    cmp("fullLider", int'(bus.lider_o), 1);
    cmp("fullEstado", int'(bus.estado_o), 0);

    // Demand right away: held off until MIN_OFF+1 edges after IDLE entry.
    applyStimulus(3'b000, 2'b00, 1'b1, 1'b0);
    ticks(8);
    cmp("minOff", int'(bus.bomba_o), 0);
    tick();
    cmp("secondStart", int'(bus.bomba_o), 2);
    ticks(63);
    cmp("timeoutEarly", int'(bus.alarma_o), 0);
    tick();
    cmp("timeoutAlarma", int'(bus.alarma_o), 1);
    cmp("timeoutCausa", int'(bus.causa_o), 2);
    cmp("timeoutBomba", int'(bus.bomba_o), 0);
    clearAlarm();
    cmp("clearEstado", int'(bus.estado_o), 0);
    cmp("clearCausa", int'(bus.causa_o), 0);

    // Short invalid glitch is filtered, a held one latches cause 01.
    applyStimulus(3'b101, 2'b00, 1'b1, 1'b0);
    ticks(3);
    applyStimulus(3'b111, 2'b00, 1'b1, 1'b0);
    ticks(8);
    cmp("glitchIgnored", int'(bus.alarma_o), 0);
    applyStimulus(3'b101, 2'b00, 1'b1, 1'b0);
    ticks(8);
    cmp("invalidAlarma", int'(bus.alarma_o), 1);
    cmp("invalidCausa", int'(bus.causa_o), 1);
    clearAlarm();
    cmp("invalidClear", int'(bus.estado_o), 0);

    // Pump faults from a fresh reset with lead 0.
    resetDut();
    applyStimulus(3'b000, 2'b00, 1'b1, 1'b0);
    ticks(7);
    cmp("faultStart", int'(bus.bomba_o), 1);
    applyStimulus(3'b000, 2'b01, 1'b1, 1'b0);
    ticks(2);
    cmp("faultEarly", int'(bus.bomba_o), 1);
    tick();
    cmp("faultLider", int'(bus.lider_o), 1);
    cmp("faultBomba", int'(bus.bomba_o), 2);
    applyStimulus(3'b000, 2'b11, 1'b1, 1'b0);
    ticks(3);
    cmp("bothCausa", int'(bus.causa_o), 3);
    cmp("bothAlarma", int'(bus.alarma_o), 1);

    // Enable drop ends a fill, then async reset mid-fill zeroes outputs at once.
    applyStimulus(3'b000, 2'b00, 1'b1, 1'b0);
    resetDut();
    ticks(7);
    cmp("enaStart", int'(bus.bomba_o), 1);
    applyStimulus(3'b000, 2'b00, 1'b0, 1'b0);
    tick();
    cmp("enaBomba", int'(bus.bomba_o), 0);
    applyStimulus(3'b000, 2'b00, 1'b1, 1'b0);
    ticks(10);
    cmp("enaRestart", int'(bus.bomba_o), 1);
    #2 rst_n = 1'b0;
    #1;
    cmp("asyncBomba", int'(bus.bomba_o), 0);
    cmp("asyncAlarma", int'(bus.alarma_o), 0);
    cmp("asyncEstado", int'(bus.estado_o), 0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Random pin activity: mostly valid levels, occasional faults, clears and enable drops.
    holdS = 0;
    holdF = 0;
    sens  = 3'b000;
    fallo = 2'b00;
    for (int c = 0; c < 4000; c++) begin
      if (holdS == 0) begin
        if ($urandom_range(0, 19) < 18) sens = validCodes[$urandom_range(0, 3)];
        else sens = badCodes[$urandom_range(0, 3)];
        holdS = $urandom_range(1, 24);
      end
      if (holdF == 0) begin
        if ($urandom_range(0, 99) < 85) fallo = 2'b00;
        else fallo = 2'($urandom_range(1, 3));
        holdF = $urandom_range(1, 30);
      end
      holdS--;
      holdF--;
      applyStimulus(sens, fallo, ($urandom_range(0, 99) < 97),
                    ($urandom_range(0, 99) < 5));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bomba_alternador.md
# bomba_alternador

Lead/lag scheduler for two fill pumps that share one tank, built on the single-pump `bomba1` control scheme. It filters the 3-level tank sensors and starts a lead pump on low level. If the level stays low it adds the lag pump, and it alternates the lead role after every completed fill. It also enforces a minimum off time and a maximum run time, and latches an alarm with a cause code for sensor inconsistency, timeout or total pump failure. It sits between the board sensor/contactor pins and the `tt_um_*` top-level wrapper.

## Interface
- `DEB`, 4 — consecutive identical synchronized samples required to accept a new sensor value (≥1).
- `LAG_DELAY`, 16 — lead run cycles after which the lag pump starts if level is still below low.
- `MAX_RUN`, 64 — maximum cycles in a fill cycle before timeout alarm (> `LAG_DELAY`).
- `MIN_OFF`, 8 — minimum cycles in IDLE after a fill before the next start.
- All counters are 16 bits.

- `clk` in 1 — clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `ena_i` in 1 — enable; low forces IDLE (except from FALLA).
- `sensores_i` in 3 — {alto, medio, bajo}; 1 = water present at that level; asynchronous.
- `fallo_i` in 2 — per-pump fault (bit n = pump n failed); asynchronous.
- `borrar_i` in 1 — alarm clear request; synchronous.
- `bomba_o` out 2 — pump run commands.
- `lider_o` out 1 — index of the current lead pump.
- `alarma_o` out 1 — latched alarm.
- `causa_o` out 2 — alarm cause: 00 none, 01 invalid sensors, 10 timeout, 11 both pumps failed.
- `estado_o` out 3 — state code: IDLE=0, LLENA1=1, LLENA2=2, FALLA=3.

## Operation
- **Input conditioning**
  - `sensores_i` and `fallo_i` each pass through 2-flop synchronizers.
  - The sensors are then debounced. The filtered value `niv` updates only after `DEB` consecutive equal synchronized samples that differ from the current `niv`.
- **Valid sensor codes:** `niv` ∈ {000, 001, 011, 111}. Any other code is invalid.
- **Transition priority, checked each cycle:**
  1. invalid `niv`
  2. both pumps failed (`fallo`=11)
  3. timeout
  4. lead pump failure
  5. alto reached
  6. lag start
- **IDLE** (`bomba_o`=00)
  - Start condition: `niv[0]`=0 (below low), `off_cnt`≥`MIN_OFF`, `ena_i`=1, and at least one healthy pump.
  - On start → LLENA1 with `run_cnt`=0. If the pump at `lider_o` has failed, `lider_o` flips to the healthy pump on the same edge.
- **LLENA1** (lead pump on)
  - `niv[2]`=1 → IDLE; `off_cnt`=0; `lider_o` toggles if the other pump is healthy.
  - `run_cnt`=`LAG_DELAY`−1, `niv[0]`=0 and lag pump healthy → LLENA2.
  - Lead pump fails (other healthy) → `lider_o` switches to the other pump; stay in LLENA1; `run_cnt` is not cleared.
- **LLENA2** (both pumps on)
  - `niv[2]`=1 → IDLE with the same `lider_o`/`off_cnt` rules as LLENA1.
  - One pump fails → LLENA1 with the healthy pump as lead.
- **Timeout:** in LLENA1 or LLENA2, `run_cnt`=`MAX_RUN`−1 → FALLA with cause 10. `run_cnt` counts total fill time across LLENA1 and LLENA2.
- **FALLA**
  - `bomba_o`=00, `alarma_o`=1, `causa_o` holds the first cause.
  - Exits to IDLE only when `borrar_i`=1, `niv` is valid and `fallo`≠11. Exit clears `alarma_o`/`causa_o` and sets `off_cnt`=0.
- **Entry to FALLA** from any other state: invalid `niv` (cause 01) or `fallo`=11 (cause 11).
- **`ena_i`=0:** in IDLE/LLENA1/LLENA2 → IDLE next edge, `off_cnt`=0 if leaving a fill. No effect in FALLA.
- **`off_cnt`** increments in IDLE and saturates at `MIN_OFF`.

## Timing
- **Reset values:**
  - state IDLE, `bomba_o`=00, `lider_o`=0, `alarma_o`=0, `causa_o`=00, `estado_o`=0.
  - `niv`=111, `off_cnt`=`MIN_OFF`, `run_cnt`=0.
  - Debounce counters and synchronizers cleared to match `niv`/`fallo`=00.
- **Outputs:** all are decoded from registers and change on the same edge as the state register.
- **Sensor latency:** a pin change held stable reaches `niv` after 2+`DEB` edges. The state reacts on the following edge, so the pump output changes 3+`DEB` edges after the pin change.
- **`fallo_i` latency:** 2 edges to synchronized value, +1 to state/outputs.
- **Lag start:** exactly `LAG_DELAY` edges after LLENA1 entry.
- **Timeout:** exactly `MAX_RUN` edges after LLENA1 entry.
- **Minimum off time:** after a fill, the earliest restart is `MIN_OFF`+1 edges after the IDLE entry edge.
- **Asynchronous reset mid-fill:** `bomba_o`=00 immediately. The latched alarm is also cleared by reset.

## Test plan
- **Reset and first fill:** reset with pins 111, then drive 000 → `bomba_o`=01 at edge 7 (`DEB`=4); drive 111 → `bomba_o`=00, `lider_o`=1, `estado_o`=0.
- **Lag start:** hold 000 → `bomba_o`=01; exactly 16 edges later `bomba_o`=11, `estado_o`=2; drive 111 → 00.
- **Alternation and minimum off time:** second demand starts pump 1 (`bomba_o`=10). Demand asserted in IDLE does not start before `off_cnt`=8.
- **Timeout:** hold 000 for 64 cycles → `alarma_o`=1, `causa_o`=10, `bomba_o`=00; `borrar_i` pulse with valid sensors → IDLE.
- **Invalid sensors:** drive 101 stable for ≥6 cycles → FALLA with `causa_o`=01. A 3-cycle glitch to 101 is ignored.
- **Pump faults:**
  - `fallo_i`=01 during LLENA1 with lead 0 → `lider_o`=1, `bomba_o`=10.
  - `fallo_i`=11 → `causa_o`=11.
  - Async reset mid-fill → all outputs zero immediately.
